br_result_update_queue: RTL and testbench

- Buffers resolved branch results from the INT issue pipes and drains them, in order, to the GAp predictor's branch-result update port.
- Up to 2 enqueues and 2 dequeues per cycle.
- Holds updates while the predictor is in its PHT reset sequence.
- Splits a dequeue pair that would hit the same PHT bank.

---
 rtl/br_result_update_queue.sv | 181 ++++++++++++++++++
 tb/tb_br_result_update_queue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/br_result_update_queue.sv
// br_result_update_queue: in-order queue of resolved branch results feeding the GAp predictor update port.
// Optional same-cycle bypass when empty: define BR_RESULT_UPDATE_QUEUE_BYPASS_EN.
module br_result_update_queue #(
    parameter int DEPTH           = 8,
    parameter int ADDR_WIDTH      = 32,
    parameter int GH_WIDTH        = 10,
    parameter int PHT_ENTRY_WIDTH = 2,
    parameter int BANK_BITS       = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [1:0]                     enq_valid,
    output logic                           enq_ready,
    input  logic [2*ADDR_WIDTH-1:0]        enq_addr,
    input  logic [2*GH_WIDTH-1:0]          enq_gh,
    input  logic [2*PHT_ENTRY_WIDTH-1:0]   enq_prev,
    input  logic [1:0]                     enq_taken,
    input  logic [1:0]                     enq_cond,
    input  logic [1:0]                     enq_mispred,
    input  logic                           drain_hold,
    output logic [1:0]                     deq_valid,
    output logic [2*ADDR_WIDTH-1:0]        deq_addr,
    output logic [2*GH_WIDTH-1:0]          deq_gh,
    output logic [2*PHT_ENTRY_WIDTH-1:0]   deq_prev,
    output logic [1:0]                     deq_taken,
    output logic [1:0]                     deq_cond,
    output logic [1:0]                     deq_mispred,
    output logic [$clog2(DEPTH):0]         occupancy,
    output logic                           overflow_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]      addr;
        logic [GH_WIDTH-1:0]        gh;
        logic [PHT_ENTRY_WIDTH-1:0] prev;
        logic                       taken;
        logic                       cond;
        logic                       mispred;
    } entry_t;

    function automatic logic [BANK_BITS-1:0] bank_of(input entry_t e);
        return e.addr[2 +: BANK_BITS];
    endfunction

    // The younger entry may go alongside the older one only if they hit different
    // PHT banks and the older one does not trigger a history recovery.
    function automatic logic pair_ok(input entry_t older, input entry_t younger);
        return (bank_of(older) != bank_of(younger)) && !older.mispred;
    endfunction

    function automatic logic [1:0] popcnt2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    entry_t        last0_q, last0_d;
    entry_t        last1_q, last1_d;

    entry_t        in0, in1;
    entry_t        cmp0, cmp1;
    entry_t        cand0, cand1;
    entry_t        out0, out1;
    logic          cand_v0, cand_v1;
    logic          deq_v0, deq_v1;
    logic [1:0]    enq_n, deq_n;
    logic          wr0, wr1;
    logic [PW-1:0] head_p1, tail_p1;

`ifdef BR_RESULT_UPDATE_QUEUE_BYPASS_EN
    logic          byp;
    assign byp = (count_q == '0) && !drain_hold && rst;
`endif

    assign in0 = {enq_addr[0 +: ADDR_WIDTH], enq_gh[0 +: GH_WIDTH],
                  enq_prev[0 +: PHT_ENTRY_WIDTH], enq_taken[0], enq_cond[0], enq_mispred[0]};
    assign in1 = {enq_addr[ADDR_WIDTH +: ADDR_WIDTH], enq_gh[GH_WIDTH +: GH_WIDTH],
                  enq_prev[PHT_ENTRY_WIDTH +: PHT_ENTRY_WIDTH], enq_taken[1], enq_cond[1],
                  enq_mispred[1]};

    // Full/empty decisions use the registered count only, so enq_ready never depends on deq.
    assign enq_ready = (count_q <= CW'(DEPTH - 2));
    assign head_p1   = head_q + PW'(1);
    assign tail_p1   = tail_q + PW'(1);

    always_comb begin
        cmp0  = in0;
        cmp1  = in1;
        if (enq_valid == 2'b10) begin
            cmp0 = in1;
        end
        enq_n = enq_ready ? popcnt2(enq_valid) : 2'd0;
    end

    always_comb begin
        cand0   = mem_q[head_q];
        cand1   = mem_q[head_p1];
        cand_v0 = (count_q != '0);
        cand_v1 = (count_q >= CW'(2));
`ifdef BR_RESULT_UPDATE_QUEUE_BYPASS_EN
        if (byp) begin
            cand0   = cmp0;
            cand1   = cmp1;
            cand_v0 = (enq_n != 2'd0);
            cand_v1 = (enq_n == 2'd2);
        end
`endif
        deq_v0 = cand_v0 && !drain_hold;
        deq_v1 = cand_v1 && !drain_hold && pair_ok(cand0, cand1);
        deq_n  = popcnt2({deq_v1, deq_v0});
    end

    always_comb begin
        wr0 = (enq_n != 2'd0);
        wr1 = (enq_n == 2'd2);
`ifdef BR_RESULT_UPDATE_QUEUE_BYPASS_EN
        // Bypassed lanes skip storage; a held-back lane 1 lands at tail+1, which becomes head.
        if (byp) begin
            wr0 = 1'b0;
            wr1 = (enq_n == 2'd2) && !deq_v1;
        end
`endif
    end

    always_comb begin
        count_d    = count_q + CW'(enq_n) - CW'(deq_n);
        head_d     = head_q + PW'(deq_n);
        tail_d     = tail_q + PW'(enq_n);
        overflow_d = overflow_q | ((|enq_valid) & ~enq_ready);
        last0_d    = deq_v0 ? cand0 : last0_q;
        last1_d    = deq_v1 ? cand1 : last1_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            last0_q    <= '0;
            last1_q    <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            last0_q    <= last0_d;
            last1_q    <= last1_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr0) begin
            mem_q[tail_q] <= cmp0;
        end
        if (wr1) begin
            mem_q[tail_p1] <= cmp1;
        end
    end

    // Idle lanes replay the last payload they carried so nothing undefined reaches the predictor.
    assign out0 = deq_v0 ? cand0 : last0_q;
    assign out1 = deq_v1 ? cand1 : last1_q;

    assign deq_valid    = {deq_v1, deq_v0};
    assign deq_addr     = {out1.addr, out0.addr};
    assign deq_gh       = {out1.gh, out0.gh};
    assign deq_prev     = {out1.prev, out0.prev};
    assign deq_taken    = {out1.taken, out0.taken};
    assign deq_cond     = {out1.cond, out0.cond};
    assign deq_mispred  = {out1.mispred, out0.mispred};
    assign occupancy    = count_q;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_br_result_update_queue.sv
// Self-checking bench for br_result_update_queue: directed steps then random traffic vs a queue model.
module tb_br_result_update_queue;

    localparam int DEPTH     = 8;
    localparam int BANK_BITS = 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [9:0]  gh;
        logic [1:0]  prev;
        logic        taken;
        logic        cond;
        logic        mispred;
    } ent_t;

    logic        clk;
    logic        rst;
    logic [1:0]  enq_valid;
    logic        enq_ready;
    logic [63:0] enq_addr;
    logic [19:0] enq_gh;
    logic [3:0]  enq_prev;
    logic [1:0]  enq_taken, enq_cond, enq_mispred;
    logic        drain_hold;
    logic [1:0]  deq_valid;
    logic [63:0] deq_addr;
    logic [19:0] deq_gh;
    logic [3:0]  deq_prev;
    logic [1:0]  deq_taken, deq_cond, deq_mispred;
    logic [3:0]  occupancy;
    logic        overflow_err;

    br_result_update_queue #(
        .DEPTH(DEPTH), .ADDR_WIDTH(32), .GH_WIDTH(10), .PHT_ENTRY_WIDTH(2), .BANK_BITS(BANK_BITS)
    ) dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_addr(enq_addr), .enq_gh(enq_gh), .enq_prev(enq_prev),
        .enq_taken(enq_taken), .enq_cond(enq_cond), .enq_mispred(enq_mispred),
        .drain_hold(drain_hold),
        .deq_valid(deq_valid), .deq_addr(deq_addr), .deq_gh(deq_gh), .deq_prev(deq_prev),
        .deq_taken(deq_taken), .deq_cond(deq_cond), .deq_mispred(deq_mispred),
        .occupancy(occupancy), .overflow_err(overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    ent_t mq[$];
    logic ov_m;
    ent_t last_m [2];
    logic known_m [2];
    ent_t Z;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int bank(input logic [31:0] a);
        return int'((a / 4) % (1 << BANK_BITS));
    endfunction

    function automatic ent_t dut_lane(input int k);
        return {deq_addr[k*32 +: 32], deq_gh[k*10 +: 10], deq_prev[k*2 +: 2],
                deq_taken[k], deq_cond[k], deq_mispred[k]};
    endfunction

    function automatic ent_t mk(input logic [31:0] a, input logic mp);
        ent_t e;
        e.addr    = a;
        e.gh      = 10'($urandom);
        e.prev    = 2'($urandom);
        e.taken   = 1'($urandom);
        e.cond    = 1'($urandom);
        e.mispred = mp;
        return e;
    endfunction

    function automatic ent_t rnd();
        return mk($urandom & 32'hFFFF_FFFC, $urandom_range(0, 5) == 0);
    endfunction

    task automatic do_reset();
        enq_valid  = 2'b00;
        drain_hold = 1'b0;
        rst        = 1'b0;
        #1;
        mq.delete();
        ov_m       = 1'b0;
        known_m[0] = 1'b0;
        known_m[1] = 1'b0;
        check("rst_occupancy", 64'(occupancy), 64'(0));
        check("rst_deq_valid", 64'(deq_valid), 64'(0));
        check("rst_enq_ready", 64'(enq_ready), 64'(1));
        check("rst_overflow", 64'(overflow_err), 64'(0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic step(input logic [1:0] v, input ent_t e0, input ent_t e1, input logic hold);
        ent_t       acc[$];
        int         occ;
        logic       exp_ready;
        logic       pushed;
        logic [1:0] ev;
        enq_valid   = v;
        enq_addr    = {e1.addr, e0.addr};
        enq_gh      = {e1.gh, e0.gh};
        enq_prev    = {e1.prev, e0.prev};
        enq_taken   = {e1.taken, e0.taken};
        enq_cond    = {e1.cond, e0.cond};
        enq_mispred = {e1.mispred, e0.mispred};
        drain_hold  = hold;
        #1;
        occ       = mq.size();
        exp_ready = (occ <= DEPTH - 2);
        if (v[0]) acc.push_back(e0);
        if (v[1]) acc.push_back(e1);
        pushed = 1'b0;
`ifdef BR_RESULT_UPDATE_QUEUE_BYPASS_EN
        if (occ == 0 && !hold) begin
            mq     = acc;
            pushed = 1'b1;
        end
`endif
        ev = 2'b00;
        if (!hold && mq.size() >= 1) begin
            ev[0] = 1'b1;
            if (mq.size() >= 2 && bank(mq[0].addr) != bank(mq[1].addr) && !mq[0].mispred)
                ev[1] = 1'b1;
        end
        if (ev[0]) begin last_m[0] = mq[0]; known_m[0] = 1'b1; end
        if (ev[1]) begin last_m[1] = mq[1]; known_m[1] = 1'b1; end
        check("enq_ready", 64'(enq_ready), 64'(exp_ready));
        check("occupancy", 64'(occupancy), 64'(occ));
        check("overflow_err", 64'(overflow_err), 64'(ov_m));
        check("deq_valid", 64'(deq_valid), 64'(ev));
        if (known_m[0]) check("deq_lane0", 64'(dut_lane(0)), 64'(last_m[0]));
        if (known_m[1]) check("deq_lane1", 64'(dut_lane(1)), 64'(last_m[1]));
        @(posedge clk);
        for (int k = 0; k < int'(ev[0]) + int'(ev[1]); k++) void'(mq.pop_front());
        if (!pushed && exp_ready) begin
            foreach (acc[k]) mq.push_back(acc[k]);
        end
        if (v != 2'b00 && !exp_ready) ov_m = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, Z, Z, 1'b0);
    endtask

    initial begin
        Z           = '0;
        rst         = 1'b1;
        enq_valid   = 2'b00;
        enq_addr    = '0;
        enq_gh      = '0;
        enq_prev    = '0;
        enq_taken   = '0;
        enq_cond    = '0;
        enq_mispred = '0;
        drain_hold  = 1'b0;
        #2;
        do_reset();

        // lane 1 only
        step(2'b10, Z, mk(32'h1004, 1'b0), 1'b0);
        idle(2);

        // same-bank pair splits, different-bank pair goes together
        step(2'b11, mk(32'h1000, 1'b0), mk(32'h1008, 1'b0), 1'b0);
        idle(3);
        step(2'b11, mk(32'h1000, 1'b0), mk(32'h1004, 1'b0), 1'b0);
        idle(2);

        // mispredict ordering
        step(2'b11, mk(32'h1000, 1'b1), mk(32'h1004, 1'b0), 1'b0);
        idle(3);

        // fill to 7 under hold, overflow, then drain across the wrap
        step(2'b01, rnd(), Z, 1'b1);
        for (int i = 0; i < 3; i++) step(2'b11, rnd(), rnd(), 1'b1);
        step(2'b11, rnd(), rnd(), 1'b1);
        step(2'b01, rnd(), Z, 1'b1);
        idle(8);

        // reset in the middle of a drain
        step(2'b11, rnd(), rnd(), 1'b1);
        step(2'b11, rnd(), rnd(), 1'b1);
        step(2'b01, rnd(), Z, 1'b1);
        step(2'b00, Z, Z, 1'b0);
        do_reset();
        step(2'b01, mk(32'h3000, 1'b0), Z, 1'b0);
        idle(2);

        // taken branch into an empty queue
        step(2'b01, '{addr: 32'h2000, gh: 10'h15, prev: 2'b10, taken: 1'b1, cond: 1'b1, mispred: 1'b0},
             Z, 1'b0);
        idle(2);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(2'($urandom), rnd(), rnd(), $urandom_range(0, 4) == 0);
        end
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
